// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared types and helpers for the pushbutton conditioner.
//   rep_state_t   : per-channel press/auto-repeat state
//   arb_state_t   : output arbiter state
//   BTN_*         : channel index of each button in the 4-bit buses
//   count_width   : counter width able to hold values 0 .. n-1
//   priority_pick : one-hot of the lowest set request bit (left wins)
// ---------------------------------------------------------------------------
package cfg_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    typedef enum logic {
        READY = 1'b0,
        GAP   = 1'b1
    } arb_state_t;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int NUM_BTN   = 4;

    // Width needed to count 0 .. n-1; never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lowest index has the highest priority: left > right > up > down.
    function automatic logic [NUM_BTN-1:0] priority_pick(input logic [NUM_BTN-1:0] req);
        logic [NUM_BTN-1:0] pick;
        pick = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One pushbutton lane: 2-FF synchroniser, debounce filter and a press /
// auto-repeat state machine that produces single-cycle events.
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   raw          : raw button level, asynchronous to clk
//   press_event  : one-cycle event (initial press or auto-repeat)
// ---------------------------------------------------------------------------
module button_channel
    import cfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int REPEAT_RATE_CYCLES  = 10_000_000,
    parameter bit REPEAT_ENABLE       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press_event
);

    localparam int DB_W = count_width(DEBOUNCE_CYCLES);
    localparam int TM_W = count_width((REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE_CYCLES - 1);

    logic            s1_reg;
    logic            s2_reg;
    logic            stable_reg;
    logic [DB_W-1:0] db_count_reg;
    rep_state_t      rep_state_reg;
    logic [TM_W-1:0] timer_reg;

    // Synchroniser and debounce: the stable level only follows s2 after
    // DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            stable_reg   <= 1'b0;
            db_count_reg <= '0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
            if (s2_reg == stable_reg) begin
                db_count_reg <= '0;
            end else if (db_count_reg == DB_LAST) begin
                stable_reg   <= s2_reg;
                db_count_reg <= '0;
            end else begin
                db_count_reg <= db_count_reg + 1'b1;
            end
        end
    end

    // The event is decoded from registered state so the pending register
    // in the top captures it on the same edge the FSM advances; this keeps
    // the press-to-pulse latency at DEBOUNCE_CYCLES+3 edges.
    always_comb begin
        press_event = 1'b0;
        if (stable_reg) begin
            case (rep_state_reg)
                RELEASED: press_event = 1'b1;
                HOLD:     press_event = REPEAT_ENABLE && (timer_reg == DELAY_LAST);
                REPEAT:   press_event = (timer_reg == RATE_LAST);
                default:  press_event = 1'b0;
            endcase
        end
    end

    // Press / auto-repeat FSM. Releasing the button always returns to
    // RELEASED silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_state_reg <= RELEASED;
            timer_reg     <= '0;
        end else if (!stable_reg) begin
            rep_state_reg <= RELEASED;
            timer_reg     <= '0;
        end else begin
            case (rep_state_reg)
                RELEASED: begin
                    rep_state_reg <= HOLD;
                    timer_reg     <= '0;
                end
                HOLD: begin
                    if (!REPEAT_ENABLE) begin
                        timer_reg <= '0;
                    end else if (timer_reg == DELAY_LAST) begin
                        rep_state_reg <= REPEAT;
                        timer_reg     <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (timer_reg == RATE_LAST) begin
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    rep_state_reg <= RELEASED;
                    timer_reg     <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions the four board pushbuttons for the MAC-address configuration
// FSM. Each button runs through a button_channel; events are latched in a
// pending register and an arbiter emits at most one registered single-cycle
// pulse followed by a forced idle cycle.
//   clk                       : system clock
//   reset                     : asynchronous, active-high reset
//   btnl/btnr/btnu/btnd_raw   : raw buttons, asynchronous to clk
//   button_left/right/up/down : one-cycle conditioned pulses
// ---------------------------------------------------------------------------
module button_conditioner
    import cfg_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES     = 1_000_000,
    parameter int         REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int         REPEAT_RATE_CYCLES  = 10_000_000,
    parameter logic [3:0] REPEAT_EN           = 4'b1100
) (
    input  logic clk,
    input  logic reset,
    input  logic btnl_raw,
    input  logic btnr_raw,
    input  logic btnu_raw,
    input  logic btnd_raw,
    output logic button_left,
    output logic button_right,
    output logic button_up,
    output logic button_down
);

    logic [NUM_BTN-1:0] raw_bus;
    logic [NUM_BTN-1:0] event_bus;
    logic [NUM_BTN-1:0] pending_reg;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] pulse_reg;
    arb_state_t         arb_state_reg;

    assign raw_bus[BTN_LEFT]  = btnl_raw;
    assign raw_bus[BTN_RIGHT] = btnr_raw;
    assign raw_bus[BTN_UP]    = btnu_raw;
    assign raw_bus[BTN_DOWN]  = btnd_raw;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_channel
            button_channel #(
                .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
                .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
                .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
                .REPEAT_ENABLE       (REPEAT_EN[gi])
            ) u_channel (
                .clk         (clk),
                .reset       (reset),
                .raw         (raw_bus[gi]),
                .press_event (event_bus[gi])
            );
        end
    endgenerate

    // Only a READY arbiter consumes a pending bit.
    assign grant = (arb_state_reg == READY) ? priority_pick(pending_reg) : '0;

    // New events OR in after the clear, so a simultaneous set wins; repeated
    // events on a set bit simply merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg & ~grant) | event_bus;
        end
    end

    // Every pulse is followed by one GAP cycle so the consumer sees
    // IDLE -> action -> IDLE for each event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_state_reg <= READY;
            pulse_reg     <= '0;
        end else begin
            case (arb_state_reg)
                READY: begin
                    pulse_reg <= grant;
                    if (|pending_reg) begin
                        arb_state_reg <= GAP;
                    end
                end
                GAP: begin
                    pulse_reg     <= '0;
                    arb_state_reg <= READY;
                end
                default: begin
                    pulse_reg     <= '0;
                    arb_state_reg <= READY;
                end
            endcase
        end
    end

    assign button_left  = pulse_reg[BTN_LEFT];
    assign button_right = pulse_reg[BTN_RIGHT];
    assign button_up    = pulse_reg[BTN_UP];
    assign button_down  = pulse_reg[BTN_DOWN];

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios followed by randomized button activity, compared every
// cycle against a behavioural model of the conditioner.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int         DC  = 4;
    localparam int         RD  = 20;
    localparam int         RR  = 8;
    localparam logic [3:0] REN = 4'b1100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btnl_raw = 1'b0;
    logic btnr_raw = 1'b0;
    logic btnu_raw = 1'b0;
    logic btnd_raw = 1'b0;
    logic button_left;
    logic button_right;
    logic button_up;
    logic button_down;
    logic [3:0] dut_out;

    int checks = 0;
    int failures = 0;
    int sc_step = 0;
    int pulse_count [4];
    int first_pulse [4];
    int last_pulse  [4];
    logic [3:0] prev_out = 4'b0000;

    button_conditioner #(
        .DEBOUNCE_CYCLES     (DC),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR),
        .REPEAT_EN           (REN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btnl_raw     (btnl_raw),
        .btnr_raw     (btnr_raw),
        .btnu_raw     (btnu_raw),
        .btnd_raw     (btnd_raw),
        .button_left  (button_left),
        .button_right (button_right),
        .button_up    (button_up),
        .button_down  (button_down)
    );

    always #5 clk = ~clk;

    assign dut_out = {button_down, button_up, button_right, button_left};

    // ---------------- behavioural model ----------------
    // Debounce: the level flips once the last DC synchronised samples all
    // disagree with it. Presses: an event one edge after the level rises,
    // then (if enabled) every RR edges starting RD edges after the press.
    logic [DC:0] m_hist [4];     // bit k = raw sampled k+1 edges ago
    logic [3:0]  m_stable, m_pend, m_out, m_ev, m_pick, m_stable_new, m_raw;
    logic        m_gap, m_diff;
    int          m_age [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_hist[ch] = '0;
                m_age[ch]  = -1;
            end
            m_stable = '0;
            m_pend   = '0;
            m_out    = '0;
            m_gap    = 1'b0;
        end else begin
            m_raw = {btnd_raw, btnu_raw, btnr_raw, btnl_raw};
            for (int ch = 0; ch < 4; ch++) begin
                m_ev[ch] = 1'b0;
                if (m_stable[ch]) begin
                    if (m_age[ch] < 0) begin
                        m_ev[ch]  = 1'b1;
                        m_age[ch] = 0;
                    end else begin
                        m_age[ch]++;
                        if (REN[ch] && m_age[ch] >= RD && ((m_age[ch] - RD) % RR) == 0)
                            m_ev[ch] = 1'b1;
                    end
                end else begin
                    m_age[ch] = -1;
                end
                m_diff = 1'b1;
                for (int k = 1; k <= DC; k++)
                    if (m_hist[ch][k] == m_stable[ch]) m_diff = 1'b0;
                m_stable_new[ch] = m_diff ? ~m_stable[ch] : m_stable[ch];
                m_hist[ch] = {m_hist[ch][DC-1:0], m_raw[ch]};
            end
            if (!m_gap && m_pend != 4'b0000) begin
                m_pick = m_pend & (~m_pend + 4'b0001);
                m_out  = m_pick;
                m_pend = m_pend & ~m_pick;
                m_gap  = 1'b1;
            end else begin
                m_out = '0;
                m_gap = 1'b0;
            end
            m_pend   = m_pend | m_ev;
            m_stable = m_stable_new;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check_outputs(input string tag);
        checks++;
        assert (dut_out === m_out) else begin
            failures++;
            $error("FAIL %s step=%0d outputs=%b expected=%b", tag, sc_step, dut_out, m_out);
        end
        checks++;
        assert ($onehot0(dut_out) === 1'b1) else begin
            failures++;
            $error("FAIL %s_onehot step=%0d outputs=%b expected=at most one high", tag, sc_step, dut_out);
        end
        checks++;
        assert (((|dut_out) && (|prev_out)) === 1'b0) else begin
            failures++;
            $error("FAIL %s_gap step=%0d outputs=%b previous=%b expected=idle cycle between pulses",
                   tag, sc_step, dut_out, prev_out);
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (dut_out[ch] === 1'b1) begin
                pulse_count[ch]++;
                if (first_pulse[ch] < 0) first_pulse[ch] = sc_step;
                last_pulse[ch] = sc_step;
            end
        end
        if (|dut_out) $display("pulse %s step=%0d outputs=%b", tag, sc_step, dut_out);
        prev_out = dut_out;
    endtask

    task automatic begin_scenario();
        sc_step = 0;
        for (int ch = 0; ch < 4; ch++) begin
            pulse_count[ch] = 0;
            first_pulse[ch] = -1;
            last_pulse[ch]  = -1;
        end
    endtask

    task automatic step(input logic [3:0] raw, input string tag);
        {btnd_raw, btnu_raw, btnr_raw, btnl_raw} = raw;
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
        sc_step++;
    endtask

    task automatic hold(input logic [3:0] raw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(raw, tag);
    endtask

    task automatic expect_int(input int observed, input int expected, input string tag);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic expect_counts(input int l, input int r, input int u, input int d, input string tag);
        expect_int(pulse_count[0], l, {tag, "_left_count"});
        expect_int(pulse_count[1], r, {tag, "_right_count"});
        expect_int(pulse_count[2], u, {tag, "_up_count"});
        expect_int(pulse_count[3], d, {tag, "_down_count"});
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] rnd_level;
    int         rnd_left [4];

    initial begin
        begin_scenario();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset_state");
        expect_int(int'(dut_out), 0, "reset_outputs_zero");
        reset = 1'b0;

        // Clean press of up: one pulse after edge 7, nothing on release.
        begin_scenario();
        hold(4'b0100, 10, "clean_press");
        hold(4'b0000, 20, "clean_release");
        expect_counts(0, 0, 1, 0, "clean");
        expect_int(first_pulse[2], 7, "clean_first_up");

        // Bouncing left for 20 cycles, then steady high.
        begin_scenario();
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000, "bounce");
        hold(4'b0001, 15, "bounce_hold");
        hold(4'b0000, 15, "bounce_release");
        expect_counts(1, 0, 0, 0, "bounce");
        expect_int(first_pulse[0], 27, "bounce_first_left");

        // Auto-repeat on down: pulses at 7, 27, 35, 43, 51, 59.
        begin_scenario();
        hold(4'b1000, 60, "repeat_down");
        hold(4'b0000, 20, "repeat_down_release");
        expect_counts(0, 0, 0, 6, "repeat_down");
        expect_int(first_pulse[3], 7, "repeat_first_down");
        expect_int(last_pulse[3], 59, "repeat_last_down");

        // Right has no auto-repeat.
        begin_scenario();
        hold(4'b0010, 60, "hold_right");
        hold(4'b0000, 20, "hold_right_release");
        expect_counts(0, 1, 0, 0, "hold_right");

        // Simultaneous press: priority order with idle cycles between.
        begin_scenario();
        hold(4'b1111, 16, "simultaneous");
        hold(4'b0000, 20, "simultaneous_release");
        expect_counts(1, 1, 1, 1, "simultaneous");
        expect_int(first_pulse[0], 7, "simul_left_edge");
        expect_int(first_pulse[1], 9, "simul_right_edge");
        expect_int(first_pulse[2], 11, "simul_up_edge");
        expect_int(first_pulse[3], 13, "simul_down_edge");

        // Reset while left is pulsing and up is pending.
        begin_scenario();
        hold(4'b0101, 8, "pre_reset");
        expect_int(first_pulse[0], 7, "pre_reset_left_edge");
        reset = 1'b1;
        #1;
        check_outputs("reset_async");
        expect_int(int'(dut_out), 0, "reset_async_zero");
        @(negedge clk);
        step(4'b0100, "in_reset");
        reset = 1'b0;
        begin_scenario();
        hold(4'b0100, 12, "post_reset");
        hold(4'b0000, 20, "post_reset_release");
        expect_counts(0, 0, 1, 0, "post_reset");
        expect_int(first_pulse[2], 7, "post_reset_up_edge");

        // Glitch shorter than the debounce window.
        begin_scenario();
        hold(4'b0010, 3, "glitch");
        hold(4'b0000, 20, "glitch_release");
        expect_counts(0, 0, 0, 0, "glitch");

        // Randomized activity on all buttons against the model.
        begin_scenario();
        rnd_level = 4'b0000;
        for (int ch = 0; ch < 4; ch++) rnd_left[ch] = $urandom_range(1, 12);
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (rnd_left[ch] == 0) begin
                    rnd_level[ch] = ~rnd_level[ch];
                    rnd_left[ch] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 70)
                                                               : $urandom_range(1, 10);
                end
                rnd_left[ch]--;
            end
            step(rnd_level, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
